// File: rtl/fma16_pkg.sv
// Shared types and constants for the fma16 operand unpacker.
// classify() is used by the lanes and by the top-level FSM.
package fma16_pkg;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DONE
    } unpack_state_t;

    localparam int BIAS = 15;
    localparam int EMIN = -14;

    localparam int CLS_ZERO = 0;
    localparam int CLS_SUB  = 1;
    localparam int CLS_INF  = 2;
    localparam int CLS_QNAN = 3;
    localparam int CLS_SNAN = 4;

    // One-hot class of a binary16 value; all zero for a normal number.
    function automatic logic [4:0] classify(input logic [15:0] h);
        logic [4:0] c;
        c = '0;
        if (h[14:10] == 5'd0) begin
            if (h[9:0] == 10'd0) c[CLS_ZERO] = 1'b1;
            else                 c[CLS_SUB]  = 1'b1;
        end else if (h[14:10] == 5'h1f) begin
            if (h[9:0] == 10'd0) c[CLS_INF]  = 1'b1;
            else if (h[9])       c[CLS_QNAN] = 1'b1;
            else                 c[CLS_SNAN] = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/fma16_unpack_lane.sv
// One operand lane: decodes a binary16 value on load, then normalizes a
// subnormal significand one bit per step until bit 10 holds the leading one.
module fma16_unpack_lane
    import fma16_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] h,
    output logic        s,
    output logic [6:0]  e,
    output logic [10:0] m,
    output logic [4:0]  cls,
    output logic        normed
);

    logic [6:0]  e_d;
    logic [10:0] m_d;
    logic [4:0]  cls_d;
    logic        shift;

    assign cls_d = classify(h);

    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        e_d = '0;
        m_d = '0;
        if (cls_d[CLS_SUB]) begin
            e_d = 7'(EMIN);
            m_d = {1'b0, h[9:0]};
        end else if (cls_d == 5'd0) begin
            e_d = {2'b00, h[14:10]} - 7'(BIAS);
            m_d = {1'b1, h[9:0]};
        end
    end

    assign shift = step && cls[CLS_SUB] && !m[10];

    // Reports the state after this cycle's shift, so the FSM leaves NORM
    // on the same edge that sets the leading one.
    assign normed = !cls[CLS_SUB] || m[10] || m[9];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s   <= 1'b0;
            e   <= '0;
            m   <= '0;
            cls <= '0;
        end else if (load) begin
            // NOTE: non-blocking so all fields update together from pre-edge values.
            s   <= h[15];
            e   <= e_d;
            m   <= m_d;
            cls <= cls_d;
        end else if (shift) begin
            m <= {m[9:0], 1'b0};
            e <= e - 7'd1;
        end
    end

endmodule

// File: rtl/fma16_unpack.sv
// Operand unpacker top: valid/ready handshake, IDLE/NORM/DONE sequencing
// and three decode/normalize lanes. All outputs come from registers.
module fma16_unpack
    import fma16_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] z,
    input  logic [1:0]  roundmode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        xs,
    output logic        ys,
    output logic        zs,
    output logic [6:0]  xe,
    output logic [6:0]  ye,
    output logic [6:0]  ze,
    output logic [10:0] xm,
    output logic [10:0] ym,
    output logic [10:0] zm,
    output logic [4:0]  xcls,
    output logic [4:0]  ycls,
    output logic [4:0]  zcls,
    output logic        snan_any,
    output logic [1:0]  roundmode_q
);

    unpack_state_t state, next_state;
    logic          accept, load, step;
    logic          x_normed, y_normed, z_normed, all_normed;
    logic [4:0]    x_dcls, y_dcls, z_dcls;
    logic          any_sub;

    assign x_dcls     = classify(x);
    assign y_dcls     = classify(y);
    assign z_dcls     = classify(z);
    assign any_sub    = x_dcls[CLS_SUB] | y_dcls[CLS_SUB] | z_dcls[CLS_SUB];
    assign all_normed = x_normed & y_normed & z_normed;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (accept)     next_state = any_sub ? NORM : DONE;
            NORM: if (all_normed) next_state = DONE;
            DONE: if (out_ready)  next_state = IDLE;
            default:              next_state = IDLE;
        endcase
    end

    // in_ready is a register, so it reads 0 during reset and acceptance
    // starts one edge after release.
    always_comb begin
        accept = (state == IDLE) && in_ready && in_valid;
        load   = accept;
        step   = (state == NORM);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            snan_any    <= 1'b0;
            roundmode_q <= '0;
        end else begin
            in_ready  <= (next_state == IDLE);
            out_valid <= (next_state == DONE);
            if (accept) begin
                snan_any    <= x_dcls[CLS_SNAN] | y_dcls[CLS_SNAN] | z_dcls[CLS_SNAN];
                roundmode_q <= roundmode;
            end
        end
    end

    fma16_unpack_lane u_x (
        .clk(clk), .reset_n(reset_n), .load(load), .step(step), .h(x),
        .s(xs), .e(xe), .m(xm), .cls(xcls), .normed(x_normed)
    );

    fma16_unpack_lane u_y (
        .clk(clk), .reset_n(reset_n), .load(load), .step(step), .h(y),
        .s(ys), .e(ye), .m(ym), .cls(ycls), .normed(y_normed)
    );

    fma16_unpack_lane u_z (
        .clk(clk), .reset_n(reset_n), .load(load), .step(step), .h(z),
        .s(zs), .e(ze), .m(zm), .cls(zcls), .normed(z_normed)
    );

endmodule
